// File: rtl/dphy_lane_receiver.sv
// -----------------------------------------------------------------------------
// dphy_lane_receiver
//
// Single-lane MIPI D-PHY high-speed receiver. The serial lane is sampled on
// both edges of the DDR bit clock. The receiver hunts for the HS sync byte at
// either bit alignment, then deserialises the LSB-first payload into bytes.
// Each byte is presented with a one-cycle enable pulse. Once locked, the lane
// stays locked until reset; the packet layer asserts reset at packet end.
//
// Parameters:
//   SYNC_BYTE  HS leader/sync byte value, received LSB first.
//
// Ports:
//   clock_p  in   1  DDR bit clock; outputs registered on the rising edge.
//   reset    in   1  Asynchronous, active-high; returns the lane to HUNT.
//   data_p   in   1  Serial HS data lane.
//   data     out  8  Last deserialised payload byte; bit 0 received first.
//   enable   out  1  One-cycle pulse: data holds a new byte.
// -----------------------------------------------------------------------------
module dphy_lane_receiver #(
    parameter logic [7:0] SYNC_BYTE = 8'hB8
) (
    input  logic       clock_p,
    input  logic       reset,
    input  logic       data_p,
    output logic [7:0] data,
    output logic       enable
);

    typedef enum logic [0:0] {
        StHunt,
        StLocked
    } state_t;

    state_t     state_q, state_d;

    // Bit A is sampled on the rising edge, bit B on the following falling edge.
    logic       bit_a_q;
    logic       bit_b_q;

    logic [9:0] window_q, window_d;
    logic [1:0] pair_cnt_q, pair_cnt_d;
    logic       align_q, align_d;     // 0: even (newest 8 bits), 1: odd
    logic [7:0] data_q, data_d;
    logic       enable_q, enable_d;

    logic       match_even;
    logic       match_odd;
    logic [7:0] byte_even;
    logic [7:0] byte_odd;

    // -------------------------------------------------------------------------
    // Dual-edge sampling
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_p or posedge reset) begin
        if (reset) begin
            bit_a_q <= 1'b0;
        end else begin
            bit_a_q <= data_p;
        end
    end

    always_ff @(negedge clock_p or posedge reset) begin
        if (reset) begin
            bit_b_q <= 1'b0;
        end else begin
            bit_b_q <= data_p;
        end
    end

    // -------------------------------------------------------------------------
    // Shift window: one bit pair per rising edge, newest bit at the MSB.
    // A precedes B in time, so B lands above A.
    // -------------------------------------------------------------------------
    always_comb begin
        window_d = {bit_b_q, bit_a_q, window_q[9:2]};
    end

    // Candidate bytes are taken from the window as it will be after this edge,
    // so a completed byte is emitted on the edge that shifts its last pair in.
    always_comb begin
        byte_even  = window_d[9:2];
        byte_odd   = window_d[8:1];
        match_even = (byte_even == SYNC_BYTE);
        match_odd  = (byte_odd == SYNC_BYTE);
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_p or posedge reset) begin
        if (reset) begin
            state_q    <= StHunt;
            window_q   <= 10'd0;
            pair_cnt_q <= 2'd0;
            align_q    <= 1'b0;
            data_q     <= 8'h00;
            enable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            window_q   <= window_d;
            pair_cnt_q <= pair_cnt_d;
            align_q    <= align_d;
            data_q     <= data_d;
            enable_q   <= enable_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pair_cnt_d = pair_cnt_q;
        align_d    = align_q;
        data_d     = data_q;
        enable_d   = 1'b0;

        case (state_q)
            StHunt: begin
                // Even alignment takes priority when both candidates match.
                if (match_even) begin
                    state_d    = StLocked;
                    align_d    = 1'b0;
                    pair_cnt_d = 2'd0;
                end else if (match_odd) begin
                    state_d    = StLocked;
                    align_d    = 1'b1;
                    pair_cnt_d = 2'd0;
                end
            end

            StLocked: begin
                pair_cnt_d = pair_cnt_q + 2'd1;
                // Fourth pair since the last byte boundary completes a byte;
                // no re-alignment happens here, so sync-like payload passes.
                if (pair_cnt_q == 2'd3) begin
                    data_d   = align_q ? byte_odd : byte_even;
                    enable_d = 1'b1;
                end
            end

            default: begin
                state_d = StHunt;
            end
        endcase
    end

    assign data   = data_q;
    assign enable = enable_q;

endmodule

// File: tb/tb_dphy_lane_receiver.sv
`timescale 1ns/1ps
module tb_dphy_lane_receiver;

    logic       clock_p;
    logic       reset;
    logic       data_p;
    logic [7:0] data;
    logic       enable;

    dphy_lane_receiver #(.SYNC_BYTE(8'hB8)) dut (
        .clock_p(clock_p),
        .reset  (reset),
        .data_p (data_p),
        .data   (data),
        .enable (enable)
    );

    initial clock_p = 1'b0;
    always #5 clock_p = ~clock_p;

    int tests_run    = 0;
    int tests_failed = 0;

    // Rising-edge counter; a pulse produced at rising edge n is seen as cyc == n.
    int cyc = 0;
    always @(posedge clock_p) cyc = cyc + 1;

    bit         stream_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_data[$];
    int         got_cyc[$];
    int         consec_cnt = 0;
    bit         prev_en = 1'b0;
    int         even_first = 0;

    // Capture enable pulses away from the rising edge.
    always @(negedge clock_p) begin
        if (enable === 1'b1) begin
            got_data.push_back(data);
            got_cyc.push_back(cyc);
            if (prev_en) consec_cnt = consec_cnt + 1;
        end
        prev_en = (enable === 1'b1);
    end

    // Watchdog: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic void push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) stream_q.push_back(b[i]);
    endfunction

    // Starts just after a falling edge: A is sampled at the next rising edge,
    // B at the falling edge after it.
    task automatic send_pair(input bit a, input bit b);
        data_p = a;
        @(posedge clock_p);
        #1 data_p = b;
        @(negedge clock_p);
        #1;
    endtask

    task automatic send_stream();
        bit a;
        bit b;
        while (stream_q.size() > 0) begin
            a = stream_q.pop_front();
            b = (stream_q.size() > 0) ? stream_q.pop_front() : 1'b0;
            send_pair(a, b);
        end
    endtask

    task automatic do_reset();
        @(negedge clock_p);
        #1 reset = 1'b1;
        data_p = 1'b0;
        repeat (2) @(negedge clock_p);
        #1 reset = 1'b0;
        got_data.delete();
        got_cyc.delete();
        exp_q.delete();
        stream_q.delete();
        consec_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_p = 1'($urandom_range(0, 1));
            @(negedge clock_p);
            tests_run++;
            if (data !== 8'h00 || enable !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold cycle %0d: got data=%h enable=%b, required 00/0",
                         i, data, enable);
            end
            data_p = 1'($urandom_range(0, 1));
            @(posedge clock_p);
            #1;
        end
        @(negedge clock_p);
        #1 reset = 1'b0;
        got_data.delete();
        got_cyc.delete();
        for (int i = 0; i < 16; i++) send_pair(1'b0, 1'b0);
        tests_run++;
        if (got_data.size() !== 0) begin
            tests_failed++;
            $display("FAIL reset_zeros: got %0d pulses, required 0", got_data.size());
        end
    endtask

    task automatic test_even_align();
        int c;
        do_reset();
        push_byte(8'hB8);
        push_byte(8'h12); exp_q.push_back(8'h12);
        push_byte(8'h34); exp_q.push_back(8'h34);
        push_byte(8'hAB); exp_q.push_back(8'hAB);
        c = cyc;
        send_stream();
        send_pair(1'b0, 1'b0);
        send_pair(1'b0, 1'b0);
        tests_run++;
        if (got_data.size() !== 3) begin
            tests_failed++;
            $display("FAIL even_count: got %0d pulses, required 3", got_data.size());
        end
        for (int i = 0; i < 3 && got_data.size() > 0; i++) begin
            logic [7:0] e;
            logic [7:0] g;
            e = exp_q.pop_front();
            g = got_data.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL even_byte%0d: got %h, required %h", i, g, e);
            end
        end
        if (got_cyc.size() == 3) begin
            even_first = got_cyc[0] - c;
            tests_run++;
            if (even_first < 9 || even_first > 10) begin
                tests_failed++;
                $display("FAIL even_latency: got offset %0d, required 9..10", even_first);
            end
            for (int i = 1; i < 3; i++) begin
                tests_run++;
                if (got_cyc[i] - got_cyc[i-1] !== 4) begin
                    tests_failed++;
                    $display("FAIL even_spacing%0d: got %0d, required 4", i,
                             got_cyc[i] - got_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_odd_align();
        int c;
        int first;
        do_reset();
        stream_q.push_back(1'b0);
        push_byte(8'hB8);
        push_byte(8'h12); exp_q.push_back(8'h12);
        push_byte(8'h34); exp_q.push_back(8'h34);
        push_byte(8'hAB); exp_q.push_back(8'hAB);
        c = cyc;
        send_stream();
        send_pair(1'b0, 1'b0);
        send_pair(1'b0, 1'b0);
        tests_run++;
        if (got_data.size() !== 3) begin
            tests_failed++;
            $display("FAIL odd_count: got %0d pulses, required 3", got_data.size());
        end
        for (int i = 0; i < 3 && got_data.size() > 0; i++) begin
            logic [7:0] e;
            logic [7:0] g;
            e = exp_q.pop_front();
            g = got_data.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL odd_byte%0d: got %h, required %h", i, g, e);
            end
        end
        if (got_cyc.size() == 3) begin
            first = got_cyc[0] - c;
            tests_run++;
            if (first !== even_first + 1) begin
                tests_failed++;
                $display("FAIL odd_latency: got offset %0d, required %0d", first, even_first + 1);
            end
            tests_run++;
            if (got_cyc[2] - got_cyc[0] !== 8) begin
                tests_failed++;
                $display("FAIL odd_spacing: got %0d, required 8", got_cyc[2] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_async_reset();
        bit a;
        bit b;
        do_reset();
        push_byte(8'hB8);
        push_byte(8'h12); exp_q.push_back(8'h12);
        push_byte(8'h34);
        // Sync, first byte, and half of the second byte.
        for (int i = 0; i < 10; i++) begin
            a = stream_q.pop_front();
            b = stream_q.pop_front();
            send_pair(a, b);
        end
        tests_run++;
        if (got_data.size() !== 1 || got_data[0] !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL async_first: got %0d pulses, required 1 with %h",
                     got_data.size(), exp_q[0]);
        end
        exp_q.delete();
        tests_run++;
        if (data !== 8'h12) begin
            tests_failed++;
            $display("FAIL async_hold: got %h, required 12", data);
        end
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (data !== 8'h00 || enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_clear: got data=%h enable=%b, required 00/0", data, enable);
        end
        repeat (2) @(negedge clock_p);
        #1 reset = 1'b0;
        stream_q.delete();
        got_data.delete();
        got_cyc.delete();
        for (int i = 0; i < 16; i++) send_pair(1'b0, 1'b0);
        tests_run++;
        if (got_data.size() !== 0) begin
            tests_failed++;
            $display("FAIL async_nosync: got %0d pulses, required 0", got_data.size());
        end
        push_byte(8'hB8);
        push_byte(8'h5A); exp_q.push_back(8'h5A);
        send_stream();
        send_pair(1'b0, 1'b0);
        send_pair(1'b0, 1'b0);
        tests_run++;
        if (got_data.size() !== 1) begin
            tests_failed++;
            $display("FAIL async_resync_count: got %0d pulses, required 1", got_data.size());
        end else if (got_data[0] !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL async_resync_byte: got %h, required %h", got_data[0], exp_q[0]);
        end
    endtask

    task automatic test_embedded_sync();
        do_reset();
        push_byte(8'hB8);
        push_byte(8'hB8); exp_q.push_back(8'hB8);
        push_byte(8'h00); exp_q.push_back(8'h00);
        send_stream();
        send_pair(1'b0, 1'b0);
        send_pair(1'b0, 1'b0);
        tests_run++;
        if (got_data.size() !== 2) begin
            tests_failed++;
            $display("FAIL embedded_count: got %0d pulses, required 2", got_data.size());
        end
        for (int i = 0; i < 2 && got_data.size() > 0; i++) begin
            logic [7:0] e;
            logic [7:0] g;
            e = exp_q.pop_front();
            g = got_data.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL embedded_byte%0d: got %h, required %h", i, g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bad_gap;
        do_reset();
        push_byte(8'hB8);
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        send_stream();
        send_pair(1'b0, 1'b0);
        send_pair(1'b0, 1'b0);
        tests_run++;
        if (got_data.size() !== 16) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d pulses, required 16", got_data.size());
        end
        bad_gap = 0;
        for (int i = 1; i < got_cyc.size(); i++) begin
            if (got_cyc[i] - got_cyc[i-1] != 4) bad_gap++;
        end
        tests_run++;
        if (bad_gap !== 0) begin
            tests_failed++;
            $display("FAIL b2b_spacing: got %0d irregular gaps, required 0", bad_gap);
        end
        tests_run++;
        if (consec_cnt !== 0) begin
            tests_failed++;
            $display("FAIL b2b_consecutive: got %0d back-to-back enables, required 0",
                     consec_cnt);
        end
        while (got_data.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] e;
            logic [7:0] g;
            e = exp_q.pop_front();
            g = got_data.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL b2b_byte: got %h, required %h", g, e);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        data_p = 1'b0;
        test_reset();
        test_even_align();
        test_odd_align();
        test_async_reset();
        test_embedded_sync();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
